// File: rtl/rf_bank_param.sv
// Parametrised register file: one write port, NRD registered read ports, hardwired-zero r0
// and a per-register pending scoreboard. Define RF_BYPASS_EN to forward same-cycle writes to reads.
module rf_bank_param #(
  parameter int WD    = 32,
  parameter int DEPTH = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WD-1:0]     wr_data,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*WD-1:0] rd_data,
  output logic [NRD-1:0]    rd_pend,
  output logic              pend_any
);

  logic [WD-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_next;
  logic             wr_hit;
  logic             rsv_hit;

  logic [AW-1:0]    raddr   [NRD];
  logic [WD-1:0]    rdata_q [NRD];
  logic [NRD-1:0]   byp;

  assign wr_hit  = wr_en && (wr_addr != '0);
  assign rsv_hit = rsv_en && (rsv_addr != '0);

  // Reserve is applied after the write clear so a new producer keeps the register pending.
  always_comb begin
    pend_next = pend;
    if (wr_hit)
      pend_next[wr_addr] = 1'b0;
    if (rsv_hit)
      pend_next[rsv_addr] = 1'b1;
  end

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      pend <= '0;
    end else begin
      if (wr_hit)
        mem[wr_addr] <= wr_data;
      pend <= pend_next;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NRD; g++) begin : g_port
      assign raddr[g]            = rd_addr[g*AW +: AW];
      assign rd_data[g*WD +: WD] = rdata_q[g];
`ifdef RF_BYPASS_EN
      assign byp[g] = wr_hit && (wr_addr == raddr[g]);
`else
      assign byp[g] = 1'b0;
`endif
    end
  endgenerate

  // A bypassed read sees the post-edge pending bit, an ordinary read the pre-edge one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NRD; k++)
        rdata_q[k] <= '0;
      rd_pend <= '0;
    end else begin
      for (int k = 0; k < NRD; k++) begin
        if (rd_en[k]) begin
          if (byp[k]) begin
            rdata_q[k] <= wr_data;
            rd_pend[k] <= pend_next[raddr[k]];
          end else begin
            rdata_q[k] <= mem[raddr[k]];
            rd_pend[k] <= pend[raddr[k]];
          end
        end
      end
    end
  end

  assign pend_any = |pend;

endmodule

// File: tb/tb_rf_bank_param.sv
// Self-checking bench for rf_bank_param: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an array-based model of the register file.
module tb_rf_bank_param;

  localparam int WD    = 32;
  localparam int DEPTH = 32;
  localparam int NRD   = 2;
  localparam int AW    = $clog2(DEPTH);

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [WD-1:0]     wr_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*WD-1:0] rd_data;
  logic [NRD-1:0]    rd_pend;
  logic              pend_any;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  logic [WD-1:0] m_mem    [DEPTH];
  logic          m_pend   [DEPTH];
  logic [WD-1:0] exp_data [NRD];
  logic          exp_pend [NRD];
  int            m_a;

  rf_bank_param #(.WD(WD), .DEPTH(DEPTH), .NRD(NRD)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_pend  (rd_pend),
    .pend_any (pend_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: reads snapshot the current array, then the write and reserve land.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  = '0;
        m_pend[i] = 1'b0;
      end
      for (int k = 0; k < NRD; k++) begin
        exp_data[k] = '0;
        exp_pend[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < NRD; k++) begin
        if (rd_en[k]) begin
          m_a = int'(rd_addr[k*AW +: AW]);
          exp_data[k] = m_mem[m_a];
          exp_pend[k] = m_pend[m_a];
        end
      end
      if (wr_en && wr_addr != 0) begin
        m_mem[int'(wr_addr)]  = wr_data;
        m_pend[int'(wr_addr)] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0)
        m_pend[int'(rsv_addr)] = 1'b1;
`ifdef RF_BYPASS_EN
      for (int k = 0; k < NRD; k++) begin
        if (rd_en[k] && wr_en && wr_addr != 0 && rd_addr[k*AW +: AW] == wr_addr) begin
          exp_data[k] = wr_data;
          exp_pend[k] = m_pend[int'(wr_addr)];
        end
      end
`endif
    end
  end

  function automatic logic model_any();
    logic r = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      r = r | m_pend[i];
    return r;
  endfunction

  // Single compare process, sampling away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < NRD; k++) begin
        checks++;
        if (rd_data[k*WD +: WD] !== exp_data[k]) begin
          errors++;
          $display("[TB] FAIL model rd_data port%0d t=%0t: got %h expected %h", k, $time, rd_data[k*WD +: WD], exp_data[k]);
        end
        checks++;
        if (rd_pend[k] !== exp_pend[k]) begin
          errors++;
          $display("[TB] FAIL model rd_pend port%0d t=%0t: got %b expected %b", k, $time, rd_pend[k], exp_pend[k]);
        end
      end
      checks++;
      if (pend_any !== model_any()) begin
        errors++;
        $display("[TB] FAIL model pend_any t=%0t: got %b expected %b", $time, pend_any, model_any());
      end
    end
  end

  function automatic logic [NRD*AW-1:0] rep_addr(input logic [AW-1:0] a);
    logic [NRD*AW-1:0] r;
    for (int k = 0; k < NRD; k++)
      r[k*AW +: AW] = a;
    return r;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0)
      return AW'($urandom_range(0, DEPTH - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [WD-1:0] wd,
                       input logic rs, input logic [AW-1:0] ra,
                       input logic [NRD-1:0] re, input logic [NRD*AW-1:0] addrs);
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    rsv_en   = rs;
    rsv_addr = ra;
    rd_en    = re;
    rd_addr  = addrs;
  endtask

  // Drive one cycle of inputs at a falling edge and return at the next falling edge.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [WD-1:0] wd,
                               input logic rs, input logic [AW-1:0] ra,
                               input logic [NRD-1:0] re, input logic [NRD*AW-1:0] addrs);
    drive(we, wa, wd, rs, ra, re, addrs);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset pulse that spans the rising edge, so the driven write/reserve must be lost.
  task automatic resetPulse(input logic we, input logic [AW-1:0] wa, input logic [WD-1:0] wd,
                            input logic rs, input logic [AW-1:0] ra,
                            input logic [NRD-1:0] re, input logic [NRD*AW-1:0] addrs);
    drive(we, wa, wd, rs, ra, re, addrs);
    #2 reset = 1'b1;
    #6 reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int port, input logic [WD-1:0] ed,
                             input logic ep, input logic ea);
    checks++;
    if (rd_data[port*WD +: WD] !== ed) begin
      errors++;
      $display("[TB] FAIL %s rd_data port%0d: got %h expected %h", name, port, rd_data[port*WD +: WD], ed);
    end
    checks++;
    if (rd_pend[port] !== ep) begin
      errors++;
      $display("[TB] FAIL %s rd_pend port%0d: got %b expected %b", name, port, rd_pend[port], ep);
    end
    checks++;
    if (pend_any !== ea) begin
      errors++;
      $display("[TB] FAIL %s pend_any: got %b expected %b", name, pend_any, ea);
    end
  endtask

  initial begin
    logic [WD-1:0] byp_exp;
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0, '0);
    #1 reset = 1'b1;
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset then read every address");
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '1, rep_addr(AW'(a)));
      for (int k = 0; k < NRD; k++)
        checkOutput("reset_read", k, '0, 1'b0, 1'b0);
    end

    $display("[TB] zero register");
    applyStimulus(1'b1, '0, 32'hDEADBEEF, 1'b1, '0, '0, '0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '1, rep_addr('0));
    checkOutput("zero_reg", 0, '0, 1'b0, 1'b0);

    $display("[TB] write then read");
    applyStimulus(1'b1, AW'(5), 32'h12345678, 1'b0, '0, '0, '0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '1, rep_addr(AW'(5)));
    checkOutput("wr_rd_p0", 0, 32'h12345678, 1'b0, 1'b0);
    checkOutput("wr_rd_p1", 1, 32'h12345678, 1'b0, 1'b0);

    $display("[TB] scoreboard");
    applyStimulus(1'b0, '0, '0, 1'b1, AW'(9), '0, '0);
    checkOutput("reserve_hold", 0, 32'h12345678, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 2'b01, rep_addr(AW'(9)));
    checkOutput("read_pending", 0, '0, 1'b1, 1'b1);
    checkOutput("port1_hold", 1, 32'h12345678, 1'b0, 1'b1);
    applyStimulus(1'b1, AW'(9), 32'hA5A5A5A5, 1'b0, '0, '0, '0);
    checkOutput("write_clears", 0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 2'b01, rep_addr(AW'(9)));
    checkOutput("read_cleared", 0, 32'hA5A5A5A5, 1'b0, 1'b0);
    applyStimulus(1'b1, AW'(9), 32'h5A5A5A5A, 1'b1, AW'(9), '0, '0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 2'b01, rep_addr(AW'(9)));
    checkOutput("wr_rsv_same", 0, 32'h5A5A5A5A, 1'b1, 1'b1);
    applyStimulus(1'b1, AW'(9), '0, 1'b0, '0, '0, '0);

    $display("[TB] same-cycle write and read");
`ifdef RF_BYPASS_EN
    byp_exp = 32'h22;
`else
    byp_exp = 32'h11;
`endif
    applyStimulus(1'b1, AW'(3), 32'h11, 1'b0, '0, '0, '0);
    applyStimulus(1'b1, AW'(3), 32'h22, 1'b0, '0, 2'b01, rep_addr(AW'(3)));
    checkOutput("bypass", 0, byp_exp, 1'b0, 1'b0);

    $display("[TB] hold and reset");
    applyStimulus(1'b1, AW'(4), 32'h77, 1'b0, '0, '0, '0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 2'b01, rep_addr(AW'(4)));
    checkOutput("hold_base", 0, 32'h77, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, AW'(4), 32'h88, 1'b0, '0, '0, rep_addr(AW'(4)));
      checkOutput("hold", 0, 32'h77, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, '0, '0, 1'b1, AW'(6), '0, '0);
    drive(1'b1, AW'(4), 32'h99, 1'b1, AW'(4), '1, rep_addr(AW'(4)));
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_reset_p0", 0, '0, 1'b0, 1'b0);
    checkOutput("mid_reset_p1", 1, '0, 1'b0, 1'b0);
    #5 reset = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '1, rep_addr(AW'(4)));
    checkOutput("after_reset", 0, '0, 1'b0, 1'b0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 1500; n++) begin
      logic [NRD*AW-1:0] ra;
      for (int k = 0; k < NRD; k++)
        ra[k*AW +: AW] = rand_addr();
      if ($urandom_range(0, 99) == 0)
        resetPulse(1'($urandom_range(0, 1)), rand_addr(), WD'($urandom()),
                   1'($urandom_range(0, 1)), rand_addr(), NRD'($urandom()), ra);
      else
        applyStimulus(1'($urandom_range(0, 1)), rand_addr(), WD'($urandom()),
                      ($urandom_range(0, 3) == 0), rand_addr(), NRD'($urandom()), ra);
    end

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_bank_param.md
# rf_bank_param

Parametrised register file for the multicycle MIPS datapath, the generalised successor of the fixed 32×32 enable-gated flip-flop bank. It provides one write port, a configurable number of registered read ports, a hardwired-zero register 0, and a per-register pending (scoreboard) bit. The control FSM uses the pending bit to stall on a register whose producer has not yet written back. The block sits between the instruction-decode stage (reads, reservations) and the write-back stage (writes).

## Interface
Parameters:
- WD, 32, data width in bits
- DEPTH, 32, number of registers; power of two, at least 2
- NRD, 2, number of read ports, 1..4
- AW, $clog2(DEPTH), address width; derived, not overridden

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write enable
- wr_addr  in  AW  write address
- wr_data  in  WD  write data
- rsv_en  in  1  reserve request; sets the pending bit of rsv_addr
- rsv_addr  in  AW  register to reserve
- rd_en  in  NRD  per-port read enable
- rd_addr  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW]
- rd_data  out  NRD*WD  packed registered read data; port k uses bits [k*WD +: WD]
- rd_pend  out  NRD  registered pending bit of the address read on port k
- pend_any  out  1  OR of all pending bits, combinational from state

## Operation
- Storage: DEPTH words of WD bits. Register 0 always reads 0. Writes to address 0 are discarded. Register 0 can never be pending.
- Write: if wr_en is high and wr_addr≠0, mem[wr_addr] takes wr_data at the clock edge. The same edge clears pend[wr_addr].
- Reserve: if rsv_en is high and rsv_addr≠0, pend[rsv_addr] is set at the edge.
- Write and reserve to the same address in the same cycle: the data is written and the pending bit ends up set (reserve wins; a new producer has been issued).
- Write and reserve to different addresses in the same cycle: both take effect independently.
- Read port k, with rd_en[k] high at an edge:
  - rd_data[k] takes mem[rd_addr[k]].
  - rd_pend[k] takes pend[rd_addr[k]], sampled before that edge's updates.
  - With the bypass compiled in (see Configuration), a same-cycle write to the same nonzero address is forwarded instead.
- Read port k with rd_en[k] low: rd_data[k] and rd_pend[k] hold their previous values.
- Ports are independent. Any number of ports may read the same address, and all return identical values.
- Out-of-range addresses cannot occur, since DEPTH is a power of two.

## Timing
- Read latency is 1 cycle: the address is presented in cycle n and the data is valid after edge n+1.
- Write latency is 1 cycle without the bypass: a read issued one cycle after the write returns the new data.
- Reset values (asynchronous, on assertion): every mem word is 0, every pend bit is 0, rd_data is all 0, rd_pend is all 0, pend_any is 0.
- Reset asserted mid-operation: all state clears immediately, and a write or reserve in that cycle is lost. Normal operation resumes on the first edge after deassertion.
- pend_any reflects register state only; it has no same-cycle dependence on inputs.

## Configuration
- RF_BYPASS_EN defined: when a read and a write hit the same nonzero address in the same cycle, the read captures wr_data.
  - rd_pend[k] captures the post-edge pending value: 0 if the write alone occurs, 1 if a reserve to that address also occurs.
- RF_BYPASS_EN undefined: the read captures the old stored word and the pre-edge pending bit.
- All other behaviour is identical in both builds.

## Test plan
- Reset then read: assert reset, then read all DEPTH addresses on every port → rd_data=0, rd_pend=0, pend_any=0.
- Zero register: write 0xDEADBEEF to addr 0 and reserve addr 0, then read addr 0 → rd_data=0, rd_pend=0, pend_any=0.
- Write then read: write 0x12345678 to r5, next cycle read r5 on port 0 and r5 on port 1 → both ports return 0x12345678 one cycle later.
- Scoreboard:
  - Reserve r9 → pend_any=1 and reading r9 gives rd_pend=1.
  - Write r9=0xA5A5A5A5 → r9 pending clears and pend_any=0.
  - Write and reserve r9 in the same cycle → the data updates and rd_pend=1.
- Bypass: r3 holds 0x11, then in one cycle write r3=0x22 and read r3 → returns 0x22 with RF_BYPASS_EN defined, 0x11 without.
- Hold and reset: read r4 (0x77), drop rd_en for 3 cycles while writing r4=0x88 → rd_data holds 0x77. Assert reset mid-write → all outputs 0 and r4 reads 0 afterwards.
